// File: rtl/irq_controller.sv
// Prioritised, rising-edge interrupt controller: one-cycle interrupt pulse, RET-tracked service window, post-RET gap.
// Define IRQ_SYNC_EN to insert a two-flop synchroniser on each request line (+2 cycles request latency).
module irq_controller #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [NUM_SRC-1:0] irq_req_i,
  input  logic [5:0]         op_i,
  input  logic               mask_we_i,
  input  logic [NUM_SRC-1:0] mask_wdata_i,
  output logic               interrupt_o,
  output logic [2:0]         irq_id_o,
  output logic               in_service_o,
  output logic [NUM_SRC-1:0] pending_o
);

  localparam logic [5:0] OP_RET   = 6'b010000;
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_ENTRY0,
    S_ENTRY1,
    S_SERVICE,
    S_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic [2:0]         irq_id_q, irq_id_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] hist_q;
  logic [NUM_SRC-1:0] req_s;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] grant;
  logic [2:0]         win_id;
  logic               any_elig;
  logic               inhibit;
  logic               take;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_req_i;
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q;
`else
  assign req_s = irq_req_i;
`endif

  assign rise     = req_s & ~hist_q;
  assign elig     = pending_q & mask_q;
  assign any_elig = |elig;
  // Any jump/RET opcode in decode would corrupt the saved return address.
  assign inhibit  = (op_i[5:4] == 2'b01);

  always_comb begin
    grant  = '0;
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        grant  = '0;
        grant[i] = 1'b1;
        win_id = 3'(i);
      end
    end
  end

  // A fresh rising edge on the taken source outranks its clear.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_bit
    assign pending_d[gi] = rise[gi] | (pending_q[gi] & ~(take & grant[gi]));
    assign mask_d[gi]    = mask_we_i ? mask_wdata_i[gi] : mask_q[gi];
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    take      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_elig && !inhibit) begin
          state_d = S_FIRE;
          take    = 1'b1;
        end
      end
      S_FIRE:   state_d = S_ENTRY0;
      S_ENTRY0: state_d = S_ENTRY1;
      S_ENTRY1: state_d = S_SERVICE;
      S_SERVICE: begin
        if (op_i == OP_RET) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = S_IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign irq_id_d = take ? win_id : irq_id_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      gap_cnt_q <= '0;
      irq_id_q  <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      hist_q    <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      irq_id_q  <= irq_id_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      hist_q    <= req_s;
    end
  end

  assign interrupt_o  = (state_q == S_FIRE);
  assign in_service_o = (state_q == S_FIRE) || (state_q == S_ENTRY0) ||
                        (state_q == S_ENTRY1) || (state_q == S_SERVICE);
  assign irq_id_o     = irq_id_q;
  assign pending_o    = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Randomised scoreboard bench for irq_controller against a timestamp-based reference model.
module tb_irq_controller;

  localparam int NS  = 4;
  localparam int GAP = 2;
  localparam logic [5:0] OP_RET = 6'b010000;
  localparam logic [5:0] OP_JMP = 6'b011000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [NS-1:0] irq_req = '0;
  logic [5:0]    op = '0;
  logic          mask_we = 1'b0;
  logic [NS-1:0] mask_wdata = '0;
  logic          interrupt_o;
  logic [2:0]    irq_id_o;
  logic          in_service_o;
  logic [NS-1:0] pending_o;

  always #5 clk = ~clk;

  irq_controller #(.NUM_SRC(NS), .GAP_CYCLES(GAP)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .irq_req_i    (irq_req),
    .op_i         (op),
    .mask_we_i    (mask_we),
    .mask_wdata_i (mask_wdata),
    .interrupt_o  (interrupt_o),
    .irq_id_o     (irq_id_o),
    .in_service_o (in_service_o),
    .pending_o    (pending_o)
  );

  typedef struct packed {
    int         eno;
    logic [2:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: service windows described by the edge numbers of the fire and of the RET.
  logic [NS-1:0] m_pend, m_mask, m_prev;
  logic [NS-1:0] m_s1, m_s2;
  logic [2:0]    m_id;
  bit            m_serving;
  int            m_fire_edge, m_ret_edge;

  always @(posedge clk) begin : model
    logic [NS-1:0] seen, rise, elig, clr;
    int win;
    exp_t ev;
    cyc = cyc + 1;
    if (!reset_n) begin
      m_pend = '0; m_mask = '1; m_prev = '0; m_s1 = '0; m_s2 = '0; m_id = '0;
      m_serving = 0; m_fire_edge = -1000; m_ret_edge = -1000;
    end else begin
`ifdef IRQ_SYNC_EN
      seen = m_s2;
`else
      seen = irq_req;
`endif
      rise = seen & ~m_prev;
      elig = m_pend & m_mask;
      clr  = '0;
      if (m_serving) begin
        if (cyc >= m_fire_edge + 4 && op == OP_RET) begin
          m_serving  = 0;
          m_ret_edge = cyc;
        end
      end else if (cyc >= m_ret_edge + GAP + 1 && elig != '0 && op[5:4] != 2'b01) begin
        win = 0;
        for (int k = NS - 1; k >= 0; k--) if (elig[k]) win = k;
        clr[win]    = 1'b1;
        m_id        = 3'(win);
        m_serving   = 1;
        m_fire_edge = cyc;
        ev.eno = cyc;
        ev.id  = 3'(win);
        exp_q.push_back(ev);
      end
      m_pend = (m_pend & ~clr) | rise;
      m_prev = seen;
      m_s2   = m_s1;
      m_s1   = irq_req;
      if (mask_we) m_mask = mask_wdata;
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, act, req);
    end
  endfunction

  initial begin : monitor
    bit   in_rst;
    exp_t ev;
    in_rst = 0;
    forever begin
      @(negedge clk or negedge reset_n);
      if (!reset_n) begin
        if (!in_rst) begin
          in_rst = 1;
          exp_q.delete();
          #1;
          chk("rst_interrupt", 32'(interrupt_o), 32'd0);
          chk("rst_in_service", 32'(in_service_o), 32'd0);
          chk("rst_irq_id", 32'(irq_id_o), 32'd0);
          chk("rst_pending", 32'(pending_o), 32'd0);
        end
      end else begin
        in_rst = 0;
        chk("pending", 32'(pending_o), 32'(m_pend));
        chk("in_service", 32'(in_service_o), 32'(m_serving));
        chk("irq_id_hold", 32'(irq_id_o), 32'(m_id));
        if (interrupt_o === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_interrupt", 32'd1, 32'd0);
          end else begin
            ev = exp_q.pop_front();
            chk("interrupt_edge", 32'(cyc), 32'(ev.eno));
            chk("interrupt_id", 32'(irq_id_o), 32'(ev.id));
          end
        end else if (exp_q.size() != 0 && exp_q[0].eno <= cyc) begin
          ev = exp_q.pop_front();
          chk("missing_interrupt_edge", 32'(cyc), 32'(ev.eno));
        end
      end
    end
  end

  task automatic drive(input logic [NS-1:0] req, input logic [5:0] o,
                       input logic we, input logic [NS-1:0] wd);
    @(negedge clk);
    #1;
    irq_req    = req;
    op         = o;
    mask_we    = we;
    mask_wdata = wd;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(irq_req, 6'd0, 1'b0, '0);
  endtask

  task automatic ret_op();
    drive(irq_req, OP_RET, 1'b0, '0);
  endtask

  // Alternating RET/no-op lets every pending source fire and finish.
  task automatic drain();
    drive('0, 6'd0, 1'b1, '1);
    for (int i = 0; i < 80; i++) drive('0, (i % 2 == 1) ? OP_RET : 6'd0, 1'b0, '0);
    idle(6);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    irq_req = '0;
    op      = '0;
    mask_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin : stimulus
    logic [NS-1:0] tog;
    int r;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    idle(3);

    // Single request on source 2.
    drive(4'b0100, 6'd0, 1'b0, '0);
    drive(4'b0000, 6'd0, 1'b0, '0);
    idle(6); ret_op(); idle(6);

    // Sources 3 and 1 together: 1 first, 3 after RET + gap.
    drive(4'b1010, 6'd0, 1'b0, '0);
    drive(4'b0000, 6'd0, 1'b0, '0);
    idle(7); ret_op(); idle(8); ret_op(); idle(6);

    // Masked source 0 waits until the mask is reopened.
    drive(4'b0000, 6'd0, 1'b1, 4'b1110);
    drive(4'b0001, 6'd0, 1'b0, '0);
    drive(4'b0000, 6'd0, 1'b0, '0);
    idle(5);
    drive(4'b0000, 6'd0, 1'b1, 4'b1111);
    idle(7); ret_op(); idle(6);

    // Jump opcode held in decode delays the fire.
    drive(4'b0100, OP_JMP, 1'b0, '0);
    repeat (5) drive(4'b0000, OP_JMP, 1'b0, '0);
    idle(7); ret_op(); idle(6);

    // New edge on source 0 coincides with its fire edge.
    drive(4'b0001, OP_JMP, 1'b0, '0);
    repeat (3) drive(4'b0000, OP_JMP, 1'b0, '0);
    drive(4'b0001, 6'd0, 1'b0, '0);
    idle(7); ret_op(); idle(9); ret_op(); idle(6);

    // Reset during FIRE, then a normal request.
    drive(4'b0001, 6'd0, 1'b0, '0);
    drive(4'b0001, 6'd0, 1'b0, '0);
    do_reset();
    idle(2);
    drive(4'b0010, 6'd0, 1'b0, '0);
    idle(7);
    // Reset during SERVICE, then a normal request.
    do_reset();
    idle(2);
    drive(4'b1000, 6'd0, 1'b0, '0);
    drive(4'b0000, 6'd0, 1'b0, '0);
    idle(7); ret_op(); idle(6);

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      tog = '0;
      for (int b = 0; b < NS; b++) if ($urandom_range(0, 5) == 0) tog[b] = 1'b1;
      r = int'($urandom_range(0, 15));
      drive(irq_req ^ tog,
            (r < 3) ? OP_RET : (r < 6) ? {2'b01, 4'($urandom)} : 6'($urandom),
            ($urandom_range(0, 19) == 0), NS'($urandom));
      if (n % 500 == 499) do_reset();
    end

    drain();
    idle(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Prioritised interrupt controller for the 16-bit processor. It collects up to eight external requests, latches them as pending, and issues the single-cycle `interrupt` pulse that the jump-control stage consumes to save the return address and flags and vector to 0xF000. It then tracks the service routine until the decoded opcode shows RET (6'b010000), and only then re-arms for the next request.

## Interface
- NUM_SRC, 4, number of request sources (legal 1..8)
- GAP_CYCLES, 2, idle cycles enforced after RET before a new `interrupt` (legal 1..15)

- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; 0 = reset
- irq_req  input  NUM_SRC  request lines, rising-edge sensitive
- op  input  6  opcode of the instruction in the decode/jump stage
- mask_we  input  1  write strobe for mask register
- mask_wdata  input  NUM_SRC  new mask value; 1 = source enabled
- interrupt  output  1  one-cycle pulse to jump-control stage
- irq_id  output  3  index of the source last taken
- in_service  output  1  high from FIRE through SERVICE
- pending  output  NUM_SRC  latched unserviced requests

## Operation
- Edge detect: `pending[i]` sets when `irq_req[i]`=1 and its previous sample was 0. Level-high requests do not re-trigger.
- Clearing: `pending[k]` clears on the FIRE entry edge for the taken source k. If a new rising edge on k arrives on that same edge, the set wins and `pending[k]` stays 1.
- Mask:
  - Masked sources still latch pending but are not eligible.
  - `mask_we` updates the mask on the next edge.
  - Mask reset value is all ones.
- Priority: lowest index wins among `pending & mask`.
- Control-op inhibit: no IDLE→FIRE transition while `op[5:4]`=2'b01 (all jump/RET opcodes). This prevents a corrupted return address.
- FSM:
  - IDLE → FIRE when any eligible pending bit exists and the inhibit condition is false.
  - FIRE → ENTRY0 unconditionally; `interrupt`=1 only in FIRE. `irq_id` loads the winner on the FIRE entry edge.
  - ENTRY0 → ENTRY1 → SERVICE. The two cycles match the jump-control vector and flag-save pipeline.
  - SERVICE → GAP on the edge where `op`=6'b010000.
  - GAP counts GAP_CYCLES cycles, then → IDLE.
- `in_service`=1 in FIRE, ENTRY0, ENTRY1 and SERVICE.
- No nesting: new requests during FIRE..GAP only accumulate in `pending`.

## Timing
- Reset (async, immediate):
  - state = IDLE, `interrupt`=0, `in_service`=0, `irq_id`=0, `pending`=0.
  - mask = all ones, edge-detect history = 0, GAP counter = 0.
- Reset asserted mid-operation aborts any state and drops `interrupt` within the same cycle. Release resumes from IDLE.
- Latency (macro off):
  - `irq_req` rising sampled at edge N → `pending` set after N.
  - `interrupt` high from edge N+1 to N+2, if eligible and not inhibited during cycle N..N+1.
- `interrupt` is exactly one cycle wide and never asserts twice without an intervening RET plus the GAP.
- RET seen in SERVICE at edge R → GAP R..R+GAP_CYCLES → earliest next `interrupt` edge R+GAP_CYCLES+1.
- RET outside SERVICE is ignored.

## Configuration
- IRQ_SYNC_EN defined: each `irq_req` bit passes through a two-flop synchroniser (reset 0) before edge detection. This adds exactly 2 cycles to the request-to-`interrupt` latency.
- IRQ_SYNC_EN undefined: `irq_req` is sampled directly; the source must be synchronous to `clk`.

## Test plan
- Single request: pulse `irq_req`=4'b0100 at edge 10, `op`=0 → `pending`=4'b0100 after 10; `interrupt`=1 only for cycle 11–12 with `irq_id`=2; `pending`=0; `in_service`=1 until RET, then GAP of 2 cycles.
- Priority and queueing: raise sources 3 and 1 on the same edge → first service takes `irq_id`=1. After `op`=6'b010000 plus 2 GAP cycles, a second `interrupt` fires with `irq_id`=3.
- Mask and inhibit:
  - Mask = 4'b1110 with request 0 pending → no `interrupt`.
  - Writing mask 4'b1111 → fires next cycle.
  - Holding `op`=6'b011000 delays the fire until `op` changes.
- Set-wins collision: a new rising edge on source k on its FIRE edge → `pending[k]` remains 1 and fires again after RET+GAP.
- Async reset in SERVICE and in FIRE: all outputs 0 immediately, mask = all ones. A request after release fires normally. Repeat with IRQ_SYNC_EN defined and confirm latency grows by exactly 2 cycles.
